// File: rtl/reg_file_pkg.sv
// Shared widths and types for the 4x4 register file.
// Optional write-through forwarding is enabled by defining REG_FILE_BYPASS_EN.
package reg_file_pkg;

    localparam int DATA_W   = 4;
    localparam int ADDR_W   = 2;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] sel_t;

endpackage : reg_file_pkg

// File: rtl/reg_file_read_port.sv
// One combinational read port: select mux over the storage array.
// With REG_FILE_BYPASS_EN defined, a read of the register being written returns DATA_IN.
module reg_file_read_port
    import reg_file_pkg::*;
(
    input  data_t regs_i [NUM_REGS],
    input  sel_t  rd_sel_i,
    output data_t rd_data_o
`ifdef REG_FILE_BYPASS_EN
    ,
    input  logic  wr_active_i,
    input  sel_t  wr_sel_i,
    input  data_t wr_data_i
`endif
);

`ifdef REG_FILE_BYPASS_EN
    // Forward the in-flight write so the ALU sees the result in the same cycle.
    always_comb begin
        rd_data_o = regs_i[rd_sel_i];
        if (wr_active_i && (wr_sel_i == rd_sel_i)) begin
            rd_data_o = wr_data_i;
        end
    end
`else
    assign rd_data_o = regs_i[rd_sel_i];
`endif

endmodule : reg_file_read_port

// File: rtl/reg_file_4x4.sv
// 4-entry x 4-bit register file: two combinational read ports, one unconditional write port.
// Define REG_FILE_BYPASS_EN to forward DATA_IN to a read port selecting the write target.
module reg_file_4x4
    import reg_file_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  sel_t  SEL_A,
    input  sel_t  SEL_B,
    input  sel_t  SEL_W,
    input  data_t DATA_IN,
    output data_t OUT_A,
    output data_t OUT_B
);

    data_t regs_q [NUM_REGS];
    data_t regs_d [NUM_REGS];

    // There is no write enable: every non-reset edge stores DATA_IN somewhere.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        regs_d[SEL_W] = DATA_IN;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    reg_file_read_port u_read_a (
        .regs_i      (regs_q),
        .rd_sel_i    (SEL_A),
        .rd_data_o   (OUT_A)
`ifdef REG_FILE_BYPASS_EN
        ,
        .wr_active_i (rst_n),
        .wr_sel_i    (SEL_W),
        .wr_data_i   (DATA_IN)
`endif
    );

    reg_file_read_port u_read_b (
        .regs_i      (regs_q),
        .rd_sel_i    (SEL_B),
        .rd_data_o   (OUT_B)
`ifdef REG_FILE_BYPASS_EN
        ,
        .wr_active_i (rst_n),
        .wr_sel_i    (SEL_W),
        .wr_data_i   (DATA_IN)
`endif
    );

endmodule : reg_file_4x4

// File: tb/tb_reg_file_4x4.sv
// Self-checking bench for reg_file_4x4: directed scenarios then randomized traffic
// compared against an array model of the four registers.
module tb_reg_file_4x4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] SEL_A, SEL_B, SEL_W;
    logic [3:0] DATA_IN;
    logic [3:0] OUT_A, OUT_B;

    logic [3:0] model [4];
    bit         modelValid = 1'b0;
    int         checkCount = 0;
    int         passCount  = 0;

    always #5 clk = ~clk;

    reg_file_4x4 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .SEL_A   (SEL_A),
        .SEL_B   (SEL_B),
        .SEL_W   (SEL_W),
        .DATA_IN (DATA_IN),
        .OUT_A   (OUT_A),
        .OUT_B   (OUT_B)
    );

    // What a read port should show right now, given the model and the driven inputs.
    function automatic logic [3:0] expRead(input logic [1:0] sel);
`ifdef REG_FILE_BYPASS_EN
        if (rst_n && (sel == SEL_W)) return DATA_IN;
`endif
        return model[sel];
    endfunction

    task automatic checkOutput(input string tag, input logic [3:0] actual, input logic [3:0] expected);
        checkCount++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got %b expected %b (t=%0t)", tag, actual, expected, $time);
        else
            passCount++;
    endtask

    task automatic checkPorts(input string tag);
        #1;
        checkOutput({tag, "_A"}, OUT_A, expRead(SEL_A));
        checkOutput({tag, "_B"}, OUT_B, expRead(SEL_B));
    endtask

    // Drive one cycle's inputs on the falling edge, check before and after the rising edge.
    task automatic applyStimulus(input logic r, input logic [1:0] a, input logic [1:0] b,
                                 input logic [1:0] w, input logic [3:0] d, input string tag);
        @(negedge clk);
        rst_n = r; SEL_A = a; SEL_B = b; SEL_W = w; DATA_IN = d;
        if (modelValid) checkPorts({tag, "_pre"});
        @(posedge clk);
        if (!r) begin
            for (int i = 0; i < 4; i++) model[i] = 4'h0;
        end else begin
            model[w] = d;
        end
        modelValid = 1'b1;
        checkPorts({tag, "_post"});
    endtask

    // Walk both read ports across every register without clocking.
    task automatic sweepReads(input string tag);
        for (int i = 0; i < 3; i++) begin
            SEL_A = 2'(i);
            SEL_B = 2'(3 - i);
            checkPorts(tag);
        end
        SEL_A = 2'd3;
        SEL_B = 2'd0;
        #1;
        checkOutput({tag, "_A"}, OUT_A, expRead(SEL_A));
        checkOutput({tag, "_B"}, OUT_B, expRead(SEL_B));
    endtask

    initial begin
        rst_n = 1'b0; SEL_A = '0; SEL_B = '0; SEL_W = '0; DATA_IN = '0;

        // Reset clears everything; hold rst_n low so the sweep sees pure storage.
        applyStimulus(1'b0, 2'd0, 2'd0, 2'd2, 4'b1001, "reset");
        sweepReads("resetSweep");

        applyStimulus(1'b1, 2'd1, 2'd0, 2'd1, 4'b0101, "wrR1");
        applyStimulus(1'b1, 2'd1, 2'd3, 2'd3, 4'b0000, "wrR3");
        applyStimulus(1'b1, 2'd0, 2'd2, 2'd0, 4'b1010, "wrR0");
        applyStimulus(1'b1, 2'd0, 2'd2, 2'd2, 4'b0011, "wrR2");
        applyStimulus(1'b1, 2'd2, 2'd2, 2'd3, 4'b0111, "sameSel");
        sweepReads("loadedSweep");

        // Reset wins over a simultaneous write.
        applyStimulus(1'b0, 2'd1, 2'd2, 2'd1, 4'b1111, "rstDiscard");
        sweepReads("rstDiscardSweep");

        applyStimulus(1'b1, 2'd2, 2'd0, 2'd2, 4'b0110, "preload");
        applyStimulus(1'b1, 2'd2, 2'd2, 2'd2, 4'b1100, "rdDuringWr");

        for (int n = 0; n < 300; n++) begin
            applyStimulus(($urandom_range(0, 15) != 0),
                          2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                          2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), "rand");
            if ((n % 25) == 0) sweepReads("randSweep");
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule : tb_reg_file_4x4
